constant_pattern_gen: RTL and testbench

- Sequential generator that emits every input word a constant-comparison decoder with the same CMP_ENABLES/EXP_RESULT pair must accept.
- It is the producing end of the decoder's mask/value pattern: care bits are forced to EXP_RESULT, and don't-care bits are swept by a counter.
- Output is a valid/ready stream.
- Used for built-in self-test of instruction-decode match logic and as a stimulus source in core-level benches.

---
 rtl/constant_pattern_pkg.sv | 70 +++++++
 rtl/bit_scatter.sv | 38 +++
 rtl/constant_pattern_gen.sv | 208 ++++++++++++++++++++
 tb/tb_constant_pattern_gen.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/constant_pattern_pkg.sv
// -----------------------------------------------------------------------------
// constant_pattern_pkg
// Elaboration-time helpers shared by the constant pattern generator:
//   count_ones(mask)     - number of set bits in a mask
//   free_index(mask, k)  - position of the k-th clear bit (ascending), -1 if none
//   care_index(mask, j)  - position of the j-th set bit (ascending), -1 if none
//   state_t              - generator FSM state encoding
// Optional feature macro: CONSTANT_PATTERN_GEN_NEGATIVE_EN adds the NEG state.
// -----------------------------------------------------------------------------
package constant_pattern_pkg;

  // Masks are passed zero- or one-extended to this width, so the helpers work
  // for any pattern width up to 31 bits.
  localparam int MASK_W = 32;

  function automatic int count_ones(input logic [MASK_W-1:0] mask);
    int n;
    n = 0;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask[i]) n++;
    end
    return n;
  endfunction

  // Callers pad bits above the pattern width with ones so they never count
  // as free positions.
  function automatic int free_index(input logic [MASK_W-1:0] mask, input int k);
    int seen;
    int pos;
    seen = 0;
    pos  = -1;
    for (int i = 0; i < MASK_W; i++) begin
      if (!mask[i]) begin
        if (seen == k && pos < 0) pos = i;
        seen++;
      end
    end
    return pos;
  endfunction

  function automatic int care_index(input logic [MASK_W-1:0] mask, input int j);
    int seen;
    int pos;
    seen = 0;
    pos  = -1;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask[i]) begin
        if (seen == j && pos < 0) pos = i;
        seen++;
      end
    end
    return pos;
  endfunction

`ifdef CONSTANT_PATTERN_GEN_NEGATIVE_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POS  = 2'd1,
    ST_NEG  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POS  = 2'd1,
    ST_DONE = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/bit_scatter.sv
// -----------------------------------------------------------------------------
// bit_scatter
// Combinational scatter: the i-th low bit of `dense` lands on the i-th set bit
// of MASK (ascending); the result is ORed with the constant BASE.
// The caller guarantees popcount(MASK) <= DW.
// Ports:
//   dense - packed source bits
//   word  - scattered word
// -----------------------------------------------------------------------------
module bit_scatter #(
  parameter int           W    = 8,
  parameter int           DW   = 1,
  parameter logic [W-1:0] MASK = '0,
  parameter logic [W-1:0] BASE = '0
) (
  input  logic [DW-1:0] dense,
  output logic [W-1:0]  word
);

  // Number of MASK bits strictly below pos = dense index feeding bit pos.
  function automatic int rank_below(input int pos);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) begin
      if (i < pos && MASK[i]) n++;
    end
    return n;
  endfunction

  for (genvar i = 0; i < W; i++) begin : g_bit
    if (MASK[i]) begin : g_swept
      assign word[i] = BASE[i] | dense[rank_below(i)];
    end else begin : g_fixed
      assign word[i] = BASE[i];
    end
  end

endmodule

// File: rtl/constant_pattern_gen.sv
// -----------------------------------------------------------------------------
// constant_pattern_gen
// Emits, as a valid/ready stream, every word a constant-comparison decoder
// with the same CMP_ENABLES/EXP_RESULT pair accepts: care bits fixed to
// EXP_RESULT, the lowest min(F, MAX_FREE_BITS) don't-care bits swept by a
// counter, remaining don't-care bits held at 0.
// Optional macro CONSTANT_PATTERN_GEN_NEGATIVE_EN: after the positive sweep,
// emit one negative word per care bit (that bit inverted, exp_match_o=0).
// Ports:
//   clk_i        - clock, rising edge
//   arst_i       - asynchronous active-high reset
//   start_i      - begin a sweep (sampled in IDLE only)
//   pat_o        - current pattern, valid while pat_valid_o
//   exp_match_o  - 1 for a positive pattern, 0 for a negative one
//   pat_valid_o  - pattern available
//   pat_ready_i  - consumer accepts pattern
//   busy_o       - sweep in progress (including the DONE cycle)
//   done_o       - one-cycle pulse after the last transfer
// -----------------------------------------------------------------------------
module constant_pattern_gen
  import constant_pattern_pkg::*;
#(
  parameter int                  IP_WIDTH      = 10,
  parameter logic [IP_WIDTH-1:0] CMP_ENABLES   = 'h0C3,
  parameter logic [IP_WIDTH-1:0] EXP_RESULT    = 'h082,
  parameter int                  MAX_FREE_BITS = 8
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                start_i,
  output logic [IP_WIDTH-1:0] pat_o,
  output logic                exp_match_o,
  output logic                pat_valid_o,
  input  logic                pat_ready_i,
  output logic                busy_o,
  output logic                done_o
);

  localparam int NC = count_ones(MASK_W'(CMP_ENABLES));
  localparam int F  = IP_WIDTH - NC;
  localparam int FS = (F < MAX_FREE_BITS) ? F : MAX_FREE_BITS;
  localparam int SW = (FS > 0) ? FS : 1;
`ifdef CONSTANT_PATTERN_GEN_NEGATIVE_EN
  // The counter also indexes care bits in NEG, so it must reach NC.
  localparam int NW = $clog2(NC + 1);
  localparam int CW = (FS + 1 > NW) ? FS + 1 : NW;
`else
  localparam int CW = FS + 1;
`endif

  localparam logic [IP_WIDTH-1:0] BASE    = EXP_RESULT & CMP_ENABLES;
  // One extra counter bit lets the last positive transfer be detected as
  // cnt+1 == 2^FS without wrapping.
  localparam logic [CW-1:0]       POS_END = CW'(1) << FS;

  // Positions of the first FS free (don't-care) bits.
  function automatic logic [IP_WIDTH-1:0] sweep_mask(input logic [IP_WIDTH-1:0] care);
    logic [MASK_W-1:0]   padded;
    logic [IP_WIDTH-1:0] m;
    padded = '1;
    for (int i = 0; i < IP_WIDTH; i++) padded[i] = care[i];
    m = '0;
    for (int i = 0; i < IP_WIDTH; i++) begin
      for (int k = 0; k < FS; k++) begin
        if (free_index(padded, k) == i) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [IP_WIDTH-1:0] SWEEP_MASK = sweep_mask(CMP_ENABLES);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_inc;
  logic                xfer;
  logic [SW-1:0]       dense;
  logic [IP_WIDTH-1:0] scat_word;

  assign cnt_inc = cnt + CW'(1);
  assign xfer    = pat_valid_o & pat_ready_i;

  // Pattern for the count that will be current after this edge: 0 when
  // starting from IDLE, cnt+1 when advancing inside POS.
  assign dense = (state == ST_POS) ? cnt_inc[SW-1:0] : '0;

  bit_scatter #(
    .W    (IP_WIDTH),
    .DW   (SW),
    .MASK (SWEEP_MASK),
    .BASE (BASE)
  ) u_scatter (
    .dense (dense),
    .word  (scat_word)
  );

`ifdef CONSTANT_PATTERN_GEN_NEGATIVE_EN
  // One-hot selecting the j-th care bit (ascending).
  function automatic logic [IP_WIDTH-1:0] care_bit(input logic [IP_WIDTH-1:0] care,
                                                   input int j);
    logic [IP_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < IP_WIDTH; i++) begin
      if (care_index(MASK_W'(care), j) == i) r[i] = 1'b1;
    end
    return r;
  endfunction

  logic [CW-1:0]       neg_idx;
  logic [IP_WIDTH-1:0] neg_flip;

  // Index of the next negative word: 0 on entry from POS, cnt+1 inside NEG.
  assign neg_idx = (state == ST_NEG) ? cnt_inc : '0;

  always_comb begin
    // NOTE: default first so every path assigns neg_flip and no latch is inferred.
    neg_flip = '0;
    for (int j = 0; j < NC; j++) begin
      if (neg_idx == CW'(j)) neg_flip = care_bit(CMP_ENABLES, j);
    end
  end
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pat_o       <= '0;
      exp_match_o <= 1'b0;
      pat_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state       <= ST_POS;
            cnt         <= '0;
            pat_o       <= scat_word;
            exp_match_o <= 1'b1;
            pat_valid_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end

        ST_POS: begin
          if (xfer) begin
            if (cnt_inc == POS_END) begin
`ifdef CONSTANT_PATTERN_GEN_NEGATIVE_EN
              if (NC > 0) begin
                state       <= ST_NEG;
                cnt         <= '0;
                pat_o       <= BASE ^ neg_flip;
                exp_match_o <= 1'b0;
              end else begin
                state       <= ST_DONE;
                cnt         <= '0;
                pat_o       <= '0;
                exp_match_o <= 1'b0;
                pat_valid_o <= 1'b0;
                done_o      <= 1'b1;
              end
`else
              state       <= ST_DONE;
              cnt         <= '0;
              pat_o       <= '0;
              exp_match_o <= 1'b0;
              pat_valid_o <= 1'b0;
              done_o      <= 1'b1;
`endif
            end else begin
              cnt   <= cnt_inc;
              pat_o <= scat_word;
            end
          end
        end

`ifdef CONSTANT_PATTERN_GEN_NEGATIVE_EN
        ST_NEG: begin
          if (xfer) begin
            if (cnt_inc == CW'(NC)) begin
              state       <= ST_DONE;
              cnt         <= '0;
              pat_o       <= '0;
              pat_valid_o <= 1'b0;
              done_o      <= 1'b1;
            end else begin
              cnt   <= cnt_inc;
              pat_o <= BASE ^ neg_flip;
            end
          end
        end
`endif

        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_constant_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_constant_pattern_gen
// Directed bench for constant_pattern_gen: default configuration (0x0C3/0x082),
// a 12-bit configuration with capped sweep, and an all-care configuration.
// Expected words are hand-derived: free positions of 0x0C3 are 2,3,4,5,8,9.
// -----------------------------------------------------------------------------
module tb_constant_pattern_gen;

`ifdef CONSTANT_PATTERN_GEN_NEGATIVE_EN
  localparam int NEG_EN = 1;
`else
  localparam int NEG_EN = 0;
`endif
  localparam int MAIN_N = 64 + 4 * NEG_EN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst;
  logic       start;
  logic       ready;
  logic [9:0] pat;
  logic       exp_m, valid, busy, done;

  logic        n_start;
  logic [11:0] n_pat;
  logic        n_exp, n_valid, n_busy, n_done;

  logic       f_start;
  logic [9:0] f_pat;
  logic       f_exp, f_valid, f_busy, f_done;

  constant_pattern_gen u_dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .start_i     (start),
    .pat_o       (pat),
    .exp_match_o (exp_m),
    .pat_valid_o (valid),
    .pat_ready_i (ready),
    .busy_o      (busy),
    .done_o      (done)
  );

  constant_pattern_gen #(
    .IP_WIDTH(12), .CMP_ENABLES(12'h00F), .EXP_RESULT(12'h005), .MAX_FREE_BITS(4)
  ) u_narrow (
    .clk_i       (clk),
    .arst_i      (arst),
    .start_i     (n_start),
    .pat_o       (n_pat),
    .exp_match_o (n_exp),
    .pat_valid_o (n_valid),
    .pat_ready_i (1'b1),
    .busy_o      (n_busy),
    .done_o      (n_done)
  );

  constant_pattern_gen #(
    .IP_WIDTH(10), .CMP_ENABLES(10'h3FF), .EXP_RESULT(10'h155), .MAX_FREE_BITS(8)
  ) u_full (
    .clk_i       (clk),
    .arst_i      (arst),
    .start_i     (f_start),
    .pat_o       (f_pat),
    .exp_match_o (f_exp),
    .pat_valid_o (f_valid),
    .pat_ready_i (1'b1),
    .busy_o      (f_busy),
    .done_o      (f_done)
  );

  int total = 0;
  int bad   = 0;

  logic [9:0] got_pat[$];
  logic       got_exp[$];
  int         done_cycle;
  int         stall_err;
  int         drop_err;
  bit         timed_out;

  // Positive word k for the default configuration.
  function automatic logic [9:0] exp_pos(input int k);
    logic [5:0] c;
    c = k[5:0];
    return 10'h082 | {c[5], c[4], 1'b0, 1'b0, c[3], c[2], c[1], c[0], 2'b00};
  endfunction

  function automatic logic [9:0] exp_neg(input int j);
    case (j)
      0:       return 10'h083;
      1:       return 10'h080;
      2:       return 10'h0C2;
      default: return 10'h002;
    endcase
  endfunction

  function automatic logic [9:0] exp_word(input int i);
    return (i < 64) ? exp_pos(i) : exp_neg(i - 64);
  endfunction

  // Called at a negedge. Drives ready, records every transfer of the main DUT,
  // stops at done_o (done_cycle = loop index) or after max_words transfers.
  task automatic collect(input int ready_pct, input int max_words, input int limit);
    logic       held;
    logic [9:0] held_pat;
    held = 1'b0;
    held_pat = '0;
    got_pat.delete();
    got_exp.delete();
    done_cycle = -1;
    stall_err  = 0;
    drop_err   = 0;
    timed_out  = 1'b1;
    for (int c = 0; c < limit; c++) begin
      if (done) begin
        done_cycle = c;
        timed_out  = 1'b0;
        break;
      end
      ready = (ready_pct >= 100) ? 1'b1 : (int'($urandom_range(99)) < ready_pct);
      if (busy && !valid) drop_err++;
      if (valid) begin
        if (held && pat !== held_pat) stall_err++;
        if (ready) begin
          got_pat.push_back(pat);
          got_exp.push_back(exp_m);
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_pat = pat;
        end
      end
      if (max_words > 0 && got_pat.size() == max_words) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    arst = 1'b1; start = 1'b0; ready = 1'b0; n_start = 1'b0; f_start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({pat, exp_m, valid, busy, done} !== 14'd0) begin
      bad++;
      $display("FAIL reset_outputs: got pat=%h exp=%b valid=%b busy=%b done=%b want all 0",
               pat, exp_m, valid, busy, done);
    end
    arst = 1'b0;
    @(negedge clk);
    total++;
    if ({valid, busy, done} !== 3'd0) begin
      bad++;
      $display("FAIL idle_after_reset: got valid=%b busy=%b done=%b want 0", valid, busy, done);
    end
  endtask

  // Compares the collected sequence against the full expected sweep.
  task automatic check_sequence(input string name);
    total++;
    if (timed_out) begin
      bad++;
      $display("FAIL %s_timeout: got no done_o want done_o", name);
    end
    total++;
    if (got_pat.size() !== MAIN_N) begin
      bad++;
      $display("FAIL %s_count: got %0d want %0d", name, got_pat.size(), MAIN_N);
    end
    for (int i = 0; i < got_pat.size() && i < MAIN_N; i++) begin
      total++;
      if (got_pat[i] !== exp_word(i) || got_exp[i] !== (i < 64)) begin
        bad++;
        $display("FAIL %s_word%0d: got %h/%b want %h/%b", name, i, got_pat[i], got_exp[i],
                 exp_word(i), (i < 64));
      end
    end
  endtask

  task automatic test_basic();
    start = 1'b1; ready = 1'b1;
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL pre_start_valid: got %b want 0", valid);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (valid !== 1'b1 || busy !== 1'b1 || pat !== 10'h082) begin
      bad++;
      $display("FAIL start_latency: got valid=%b busy=%b pat=%h want 1 1 082", valid, busy, pat);
    end
    collect(100, 0, 200);
    check_sequence("basic");
    total++;
    if (done_cycle !== MAIN_N) begin
      bad++;
      $display("FAIL back_to_back: got done at cycle %0d want %0d", done_cycle, MAIN_N);
    end
    total++;
    if (drop_err !== 0) begin
      bad++;
      $display("FAIL basic_valid_drop: got %0d drops want 0", drop_err);
    end
    total++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL done_cycle_flags: got valid=%b busy=%b want 0 1", valid, busy);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL after_done: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_stall();
    start = 1'b1; ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    collect(30, 0, 3000);
    check_sequence("stall");
    total++;
    if (stall_err !== 0 || drop_err !== 0) begin
      bad++;
      $display("FAIL stall_stable: got %0d changes %0d drops want 0 0", stall_err, drop_err);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect(100, 20, 200);
    total++;
    if (timed_out || got_pat[19] !== exp_pos(19)) begin
      bad++;
      $display("FAIL mid_prefix: got timeout=%b word19=%h want 0 %h", timed_out, got_pat[19],
               exp_pos(19));
    end
    arst = 1'b1;
    #1;
    total++;
    if ({pat, exp_m, valid, busy, done} !== 14'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got pat=%h exp=%b valid=%b busy=%b done=%b want 0",
               pat, exp_m, valid, busy, done);
    end
    dones = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dones++;
    end
    arst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || valid) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d done/valid cycles want 0", dones);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (valid !== 1'b1 || pat !== 10'h082) begin
      bad++;
      $display("FAIL restart_first: got valid=%b pat=%h want 1 082", valid, pat);
    end
    collect(100, 0, 200);
    check_sequence("restart");
    @(negedge clk);
  endtask

  task automatic test_start_held();
    start = 1'b1; ready = 1'b1;
    @(negedge clk);
    collect(100, 0, 200);
    check_sequence("held");
    @(negedge clk);
    total++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL held_idle: got valid=%b busy=%b want 0 0", valid, busy);
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (valid !== 1'b1 || pat !== 10'h082) begin
      bad++;
      $display("FAIL held_resweep: got valid=%b pat=%h want 1 082", valid, pat);
    end
    collect(100, 0, 200);
    check_sequence("held2");
    @(negedge clk);
  endtask

  task automatic test_narrow();
    logic [11:0] q[$];
    logic        e[$];
    logic [11:0] want;
    bit          seen_done;
    int          n_exp_cnt;
    n_exp_cnt = 16 + 4 * NEG_EN;
    seen_done = 1'b0;
    n_start = 1'b1;
    @(negedge clk);
    n_start = 1'b0;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      if (n_done) seen_done = 1'b1;
      else if (n_valid) begin
        q.push_back(n_pat);
        e.push_back(n_exp);
      end
      @(negedge clk);
    end
    total++;
    if (!seen_done || q.size() !== n_exp_cnt) begin
      bad++;
      $display("FAIL narrow_count: got done=%b count=%0d want 1 %0d", seen_done, q.size(),
               n_exp_cnt);
    end
    for (int k = 0; k < q.size() && k < n_exp_cnt; k++) begin
      if (k < 16) want = 12'h005 | 12'(k << 4);
      else begin
        case (k - 16)
          0:       want = 12'h004;
          1:       want = 12'h007;
          2:       want = 12'h001;
          default: want = 12'h00D;
        endcase
      end
      total++;
      if (q[k] !== want || e[k] !== (k < 16) || (q[k] & 12'hF00) !== 12'h000) begin
        bad++;
        $display("FAIL narrow_word%0d: got %h/%b want %h/%b", k, q[k], e[k], want, (k < 16));
      end
    end
  endtask

  task automatic test_full();
    logic [9:0] q[$];
    logic       e[$];
    bit         seen_done;
    int         f_cnt;
    f_cnt = 1 + 10 * NEG_EN;
    seen_done = 1'b0;
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    for (int c = 0; c < 50 && !seen_done; c++) begin
      if (f_done) seen_done = 1'b1;
      else if (f_valid) begin
        q.push_back(f_pat);
        e.push_back(f_exp);
      end
      @(negedge clk);
    end
    total++;
    if (!seen_done || q.size() !== f_cnt) begin
      bad++;
      $display("FAIL full_count: got done=%b count=%0d want 1 %0d", seen_done, q.size(), f_cnt);
    end
    total++;
    if (q.size() < 1 || q[0] !== 10'h155 || e[0] !== 1'b1) begin
      bad++;
      $display("FAIL full_word: got %h/%b want 155/1", (q.size() > 0) ? q[0] : 10'h0,
               (e.size() > 0) ? e[0] : 1'b0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
    test_start_held();
    test_narrow();
    test_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog");
  end

endmodule
